// File: rtl/ahb_ram_subordinate.sv
// AHB-Lite subordinate in front of a word-addressed on-chip RAM with programmable wait states.
// Optional alignment/size checking is enabled by defining AHB_RAM_ALIGN_CHK_EN.
module ahb_ram_subordinate #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 4096,
  parameter int          WAIT_STATES = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic [3:0]  HWSTRB,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  logic [1:0]    state, state_nxt;
  logic [3:0]    wait_cnt, wait_cnt_nxt;
  logic          dp_active;
  logic          dp_write;
  logic [AW-1:0] dp_idx;
  logic [31:0]   hrdata_q;

  logic [31:0]   mem [DEPTH];

  logic          ready_int;
  logic          accept;
  logic [31:0]   offset;
  logic          in_range;
  logic          misaligned;
  logic          acc_ok;
  logic [AW-1:0] acc_idx;
  logic          wr_commit;
  logic          rd_at_addr;
  logic          rd_at_wait;
  logic          rd_fire;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // A new address phase is only taken in a cycle where this subordinate itself is ready.
  assign ready_int = (state == ST_IDLE) || (state == ST_ERR2);
  assign accept    = HSEL && HTRANS[1] && HREADY && ready_int;

  assign offset   = HADDR - BASE_ADDR;
  assign in_range = (HADDR >= BASE_ADDR) && ({2'b00, offset[31:2]} < 32'(DEPTH));
  assign acc_idx  = offset[AW+1:2];

`ifdef AHB_RAM_ALIGN_CHK_EN
  assign misaligned = ((HSIZE == 3'b001) && HADDR[0])
                   || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00))
                   || (HSIZE >= 3'b011);
  logic unused_bits;
  assign unused_bits = ^{HTRANS[0], offset[1:0]};
`else
  assign misaligned = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{HTRANS[0], offset[1:0], HSIZE};
`endif

  assign acc_ok = in_range && !misaligned;

  // The in-range data phase completes in the first ready cycle after its wait states.
  assign wr_commit  = dp_active && dp_write && (state == ST_IDLE);
  assign rd_at_addr = accept && acc_ok && !HWRITE && (WAIT_STATES == 0);
  assign rd_at_wait = (state == ST_WAIT) && (wait_cnt == 4'd1) && dp_active && !dp_write;
  assign rd_fire    = rd_at_addr || rd_at_wait;
  assign rd_idx     = rd_at_addr ? acc_idx : dp_idx;

  // A zero-wait read can sample the same edge a prior write commits on; forward the write.
  always_comb begin
    rd_word = mem[rd_idx];
    if (rd_at_addr && wr_commit && (dp_idx == acc_idx)) begin
      rd_word = merge_bytes(mem[rd_idx], HWDATA, HWSTRB);
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_WAIT: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) state_nxt = ST_IDLE;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: begin
        state_nxt = ST_IDLE;
        if (accept) begin
          if (!acc_ok) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = WAIT_INIT;
          end
        end
      end
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      dp_active <= 1'b0;
      dp_write  <= 1'b0;
      dp_idx    <= '0;
      hrdata_q  <= 32'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        dp_active <= acc_ok;
        dp_write  <= HWRITE;
        dp_idx    <= acc_idx;
      end else if (ready_int) begin
        dp_active <= 1'b0;
      end
      if (rd_fire) hrdata_q <= rd_word;
    end
  end

  // NOTE: the RAM array has no reset; only control state is cleared, contents survive reset.
  always_ff @(posedge CLK) begin
    if (wr_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (HWSTRB[b]) mem[dp_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
  assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_ram_subordinate.sv
// Directed bench for ahb_ram_subordinate: three instances with 0, 2 and 3 wait states.
// Build with AHB_RAM_ALIGN_CHK_EN defined to exercise the alignment-check variant.
module tb_ahb_ram_subordinate;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [3:0]  hwstrb;
  logic        hready_en;
  logic [2:0]  hro;
  logic [2:0]  hrsp;
  logic [31:0] hrd [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Instance 0: 0 wait states, 1: 2 wait states, 2: 3 wait states; 16-word RAM at 0.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    ahb_ram_subordinate #(
      .BASE_ADDR  (32'h0000_0000),
      .DEPTH      (16),
      .WAIT_STATES(WS)
    ) u_dut (
      .CLK      (clk),
      .RST      (rst),
      .HSEL     (hsel[g]),
      .HADDR    (haddr),
      .HTRANS   (htrans),
      .HWRITE   (hwrite),
      .HSIZE    (hsize),
      .HWDATA   (hwdata),
      .HWSTRB   (hwstrb),
      .HREADY   (hro[g] & hready_en),
      .HREADYOUT(hro[g]),
      .HRESP    (hrsp[g]),
      .HRDATA   (hrd[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Single transfer; entered and left 1 ns after a rising edge.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] rdata, output logic resp0, output logic resp1,
                      output int low);
    hsel      = 3'b000;
    hsel[d]   = 1'b1;
    htrans    = 2'b10;
    haddr     = addr;
    hwrite    = wr;
    hsize     = size;
    @(posedge clk); #1;
    hsel   = 3'b000;
    htrans = 2'b00;
    hwdata = wdata;
    hwstrb = strb;
    low    = 0;
    @(negedge clk);
    resp0 = hrsp[d];
    while (!hro[d] && low < 20) begin
      low++;
      @(negedge clk);
    end
    resp1 = hrsp[d];
    rdata = hrd[d];
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rdata;
    logic        r0, r1;
    int          low;

    rst = 1'b1; hsel = 3'b000; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b010; hwdata = '0; hwstrb = 4'h0; hready_en = 1'b1;
    #12;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_hreadyout%0d", d), hro[d], 1'b1);
      check($sformatf("rst_hresp%0d", d), hrsp[d], 1'b0);
      check($sformatf("rst_hrdata%0d", d), hrd[d], 32'h0);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a waited write (2 wait states)
    xfer(1, 1'b1, 32'h10, 3'b010, 32'h1234_5678, 4'hF, rdata, r0, r1, low);
    check("t1_wr_low", low, 2);
    xfer(1, 1'b0, 32'h10, 3'b010, 32'h0, 4'h0, rdata, r0, r1, low);
    check("t1_rd_low", low, 2);
    check("t1_rd_data", rdata, 32'h1234_5678);
    hsel = 3'b010; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b1;
    @(posedge clk); #1;
    hsel = 3'b000; htrans = 2'b00; hwdata = 32'hDEAD_BEEF; hwstrb = 4'hF;
    @(negedge clk);
    check("t1_in_wait", hro[1], 1'b0);
    rst = 1'b1;
    #1;
    check("t1_rst_hreadyout", hro[1], 1'b1);
    check("t1_rst_hresp", hrsp[1], 1'b0);
    check("t1_rst_hrdata", hrd[1], 32'h0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    xfer(1, 1'b0, 32'h10, 3'b010, 32'h0, 4'h0, rdata, r0, r1, low);
    check("t1_after_rst_data", rdata, 32'h1234_5678);

    // Back-to-back write then read of the same word, zero wait states
    xfer(0, 1'b1, 32'h04, 3'b010, 32'h0, 4'hF, rdata, r0, r1, low);
    hsel = 3'b001; htrans = 2'b10; haddr = 32'h04; hwrite = 1'b1; hsize = 3'b010;
    @(posedge clk); #1;
    hwdata = 32'hA5A5_1234; hwstrb = 4'hF;
    hsel = 3'b001; htrans = 2'b10; haddr = 32'h04; hwrite = 1'b0;
    @(negedge clk);
    check("t2_wr_ready", hro[0], 1'b1);
    check("t2_wr_resp", hrsp[0], 1'b0);
    @(posedge clk); #1;
    hsel = 3'b000; htrans = 2'b00; hwstrb = 4'h0;
    @(negedge clk);
    check("t2_rd_ready", hro[0], 1'b1);
    check("t2_rd_resp", hrsp[0], 1'b0);
    check("t2_rd_data", hrd[0], 32'hA5A5_1234);
    @(posedge clk); #1;

    // Three wait states
    xfer(2, 1'b1, 32'h08, 3'b010, 32'hCAFE_0008, 4'hF, rdata, r0, r1, low);
    check("t3_wr_low", low, 3);
    xfer(2, 1'b0, 32'h08, 3'b010, 32'h0, 4'h0, rdata, r0, r1, low);
    check("t3_rd_low", low, 3);
    check("t3_rd_resp", r1, 1'b0);
    check("t3_rd_data", rdata, 32'hCAFE_0008);

    // Byte-lane strobes
    xfer(0, 1'b1, 32'h0C, 3'b010, 32'h1122_3344, 4'hF, rdata, r0, r1, low);
    xfer(0, 1'b1, 32'h0C, 3'b010, 32'h00FF_0000, 4'b0100, rdata, r0, r1, low);
    xfer(0, 1'b0, 32'h0C, 3'b010, 32'h0, 4'h0, rdata, r0, r1, low);
    check("t4_strb_data", rdata, 32'h11FF_3344);
    xfer(0, 1'b1, 32'h0C, 3'b010, 32'hFFFF_FFFF, 4'b0000, rdata, r0, r1, low);
    check("t4_nostrb_resp", r1, 1'b0);
    xfer(0, 1'b0, 32'h0C, 3'b010, 32'h0, 4'h0, rdata, r0, r1, low);
    check("t4_nostrb_data", rdata, 32'h11FF_3344);

    // Range boundary: last word OK, first word past the end errors
    xfer(0, 1'b1, 32'h00, 3'b010, 32'h0BAD_F00D, 4'hF, rdata, r0, r1, low);
    xfer(0, 1'b1, 32'h3C, 3'b010, 32'h0000_003C, 4'hF, rdata, r0, r1, low);
    xfer(0, 1'b0, 32'h3C, 3'b010, 32'h0, 4'h0, rdata, r0, r1, low);
    check("t5_last_resp", r1, 1'b0);
    check("t5_last_data", rdata, 32'h0000_003C);
    xfer(0, 1'b0, 32'h40, 3'b010, 32'h0, 4'h0, rdata, r0, r1, low);
    check("t5_err_resp0", r0, 1'b1);
    check("t5_err_low", low, 1);
    check("t5_err_resp1", r1, 1'b1);
    @(negedge clk);
    check("t5_idle_ready", hro[0], 1'b1);
    check("t5_idle_resp", hrsp[0], 1'b0);
    @(posedge clk); #1;
    xfer(0, 1'b1, 32'h40, 3'b010, 32'hFFFF_FFFF, 4'hF, rdata, r0, r1, low);
    check("t5_wr_err_resp", r0, 1'b1);
    xfer(0, 1'b0, 32'h00, 3'b010, 32'h0, 4'h0, rdata, r0, r1, low);
    check("t5_no_wrap", rdata, 32'h0BAD_F00D);

    // HREADY low while idle: the address phase must be ignored
    xfer(0, 1'b1, 32'h14, 3'b010, 32'h0000_0055, 4'hF, rdata, r0, r1, low);
    hready_en = 1'b0;
    hsel = 3'b001; htrans = 2'b10; haddr = 32'h14; hwrite = 1'b1;
    @(posedge clk); #1;
    hsel = 3'b000; htrans = 2'b00; hwdata = 32'hFFFF_FFFF; hwstrb = 4'hF; hready_en = 1'b1;
    @(posedge clk); #1;
    hwstrb = 4'h0;
    xfer(0, 1'b0, 32'h14, 3'b010, 32'h0, 4'h0, rdata, r0, r1, low);
    check("t7_hready_low", rdata, 32'h0000_0055);
    @(posedge clk); @(posedge clk); #1;
    check("t7_hrdata_hold", hrd[0], 32'h0000_0055);

    // Misaligned word access at 0x02
    xfer(0, 1'b1, 32'h02, 3'b010, 32'hFFFF_FFFF, 4'hF, rdata, r0, r1, low);
`ifdef AHB_RAM_ALIGN_CHK_EN
    check("t6_align_resp", r0, 1'b1);
    check("t6_align_low", low, 1);
    xfer(0, 1'b0, 32'h00, 3'b010, 32'h0, 4'h0, rdata, r0, r1, low);
    check("t6_align_data", rdata, 32'h0BAD_F00D);
`else
    check("t6_align_resp", r0, 1'b0);
    check("t6_align_low", low, 0);
    xfer(0, 1'b0, 32'h00, 3'b010, 32'h0, 4'h0, rdata, r0, r1, low);
    check("t6_align_data", rdata, 32'hFFFF_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
